instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Fetch stage feeding decode/Controller: generates sequential PCs, issues word reads to
//  instruction memory over a valid/ready request + in-order response interface, and buffers
//  returned instructions (with their PCs) in a DEPTH-entry FIFO. Decode pops via valid/ready.
//  Branch/jump redirects flush the queue and discard in-flight responses.
// PARAMETERS
//  DEPTH     4          queue entries; power of 2, >= 2
//  RESET_PC  32'h0      fetch PC loaded on reset; word aligned
// PORTS
//  clk             in   1     clock, all state on posedge
//  reset           in   1     synchronous, active-high
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  32    byte address of request (bits[1:0]=0)
//  imem_rsp_valid  in   1     one response per accepted request, in order, latency >= 1 cycle
//  imem_rsp_data   in   32    instruction word
//  redirect_valid  in   1     branch/jump taken this cycle
//  redirect_pc     in   32    new fetch target
//  ins_valid       out  1     queue head valid
//  ins_ready       in   1     decode consumes head
//  ins_data        out  32    head instruction
//  ins_pc          out  32    head PC
//  ins_count       out  $clog2(DEPTH+1)  entries held
//  fetch_fault     out  1     misaligned-redirect fault (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: fetch_pc=rsp_pc=RESET_PC; count=outstanding=drop=0; fetch_fault=0. In reset
//    cycle and the cycle after: imem_req_valid=0, ins_valid=0, ins_count=0.
//  - Issue: imem_req_valid = (count+outstanding < DEPTH) & !redirect_valid & !fetch_fault.
//    imem_req_addr=fetch_pc. Fire (valid&ready): fetch_pc+=4 (mod 2^32), outstanding++.
//    Addr held stable while valid&!ready; valid may drop only on redirect.
//  - Response: rsp_valid retires oldest outstanding (outstanding--). If drop>0: discarded,
//    drop--. Else pushed at tail as {rsp_pc,data}; rsp_pc+=4. Response with outstanding=0
//    is illegal (assertion).
//  - Capacity reservation (count+outstanding<DEPTH) guarantees push never overflows;
//    in-flight drops still occupy reservations until they return.
//  - Pop: ins_valid = (count!=0) & !redirect_valid; fire pops head. Push+pop same cycle:
//    count unchanged, pointers both advance, wrap mod DEPTH. Pop into empty impossible;
//    push into empty queue visible on ins_valid the next cycle (no bypass).
//  - Redirect (highest priority): queue flushed (count=0, pointers reset), pop ignored,
//    no request issued; fetch_pc=rsp_pc=redirect_pc; drop = outstanding after this
//    cycle's response retirement (response arriving this cycle discarded). First new
//    request issues next cycle. Back-to-back redirects: last one wins.
//  - Latency: req fire -> rsp (mem latency L) -> ins_valid at L+1 after fire.
//  - Counters: outstanding, drop width $clog2(DEPTH+1); drop <= outstanding always.
// CONFIGURATION
//  INSTR_FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 flushes as normal
//   and sets fetch_fault=1 (sticky); no requests issue while set. Next redirect with
//   aligned PC clears fault and resumes. Reset clears fault.
//  Undefined: redirect_pc[1:0] ignored (forced 0); fetch_fault tied 0.
// TESTING
//  1 Reset, ready=1, mem L=1, ins_ready=1 -> addrs 0,4,8,C...; ins_pc 0,4,8 in order,
//    one instruction per cycle sustained.
//  2 ins_ready=0 -> exactly DEPTH(4) requests issued, ins_count=4, req_valid held 0;
//    release ready -> drains 0,4,8,C then resumes at 0x10.
//  3 Mem L=3, 3 outstanding, redirect_pc=0x100 -> those 3 responses dropped, count=0,
//    first ins_pc=0x100 with data of request to 0x100.
//  4 Redirect same cycle as rsp_valid and ins_ready=1 with count=2 -> response dropped,
//    no pop recorded, ins_valid=0 that cycle, count=0 next.
//  5 imem_req_ready toggling 1/0 randomly 200 cycles -> addr stable while stalled, PC
//    sequence gap-free, no overflow (count<=4).
//  6 (ALIGN_CHECK_EN) redirect 0x102 -> fetch_fault=1, no requests; redirect 0x200 ->
//    fault=0, fetch resumes at 0x200. Without macro: 0x102 fetches 0x100.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential-PC fetch unit issuing word reads and queueing {pc, instr} for decode.
// Latency: request fire -> memory response after L cycles -> ins_valid L+1 cycles after fire (no bypass).
// Backpressure: a request issues only while held + outstanding < DEPTH, so a stalled decode throttles fetch.
// Optional build macro INSTR_FETCH_ALIGN_CHECK_EN: misaligned redirect raises a sticky fetch_fault.
module instr_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       imem_req_valid,
   input  logic                       imem_req_ready,
   output logic [31:0]                imem_req_addr,
   input  logic                       imem_rsp_valid,
   input  logic [31:0]                imem_rsp_data,
   input  logic                       redirect_valid,
   input  logic [31:0]                redirect_pc,
   output logic                       ins_valid,
   input  logic                       ins_ready,
   output logic [31:0]                ins_data,
   output logic [31:0]                ins_pc,
   output logic [$clog2(DEPTH+1)-1:0] ins_count,
   output logic                       fetch_fault
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          started;
   logic          fault_q;
   logic [31:0]   q_data [DEPTH];
   logic [31:0]   q_pc   [DEPTH];

   logic [CW:0]   reserved;
   logic          req_fire;
   logic          push;
   logic          pop;
   logic [31:0]   redir_target;

   // Every slot is reserved at issue time, so held entries plus in-flight requests bound the queue.
   assign reserved       = {1'b0, count} + {1'b0, outstanding};
   assign redir_target   = {redirect_pc[31:2], 2'b00};

   // started keeps the request port quiet for one cycle after reset is released.
   assign imem_req_valid = started && !reset && (reserved < DEPTH_W) && !redirect_valid && !fault_q;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Responses owed to a flushed stream are discarded while drop is non-zero.
   assign push           = imem_rsp_valid && (drop == '0) && !redirect_valid;

   assign ins_valid      = !reset && (count != '0) && !redirect_valid;
   assign pop            = ins_valid && ins_ready;
   assign ins_data       = q_data[rd_ptr];
   assign ins_pc         = q_pc[rd_ptr];
   assign ins_count      = reset ? '0 : count;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
   logic redir_bad;
   assign redir_bad = |redirect_pc[1:0];

   // Sticky fault: set by a misaligned redirect, cleared by the next aligned redirect or reset.
   always_ff @(posedge clk) begin
      if (reset)
         fault_q <= 1'b0;
      else if (redirect_valid)
         fault_q <= redir_bad;
   end
`else
   logic unused_pc_lsb;
   assign unused_pc_lsb = ^redirect_pc[1:0];
   assign fault_q       = 1'b0;
`endif
   assign fetch_fault = fault_q;

   // PCs, occupancy, in-flight/drop counters and queue pointers; redirect overrides everything else.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         started     <= 1'b0;
      end else begin
         started     <= 1'b1;
         outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
         if (redirect_valid) begin
            fetch_pc <= redir_target;
            rsp_pc   <= redir_target;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            // Everything still in flight after this cycle's retirement belongs to the old stream.
            drop     <= outstanding - CW'(imem_rsp_valid);
         end else begin
            if (req_fire)
               fetch_pc <= fetch_pc + 32'd4;
            if (push) begin
               rsp_pc <= rsp_pc + 32'd4;
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            if (imem_rsp_valid && (drop != '0))
               drop <= drop - CW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // Queue storage: returned word written at the tail tagged with its PC.
   always_ff @(posedge clk) begin
      if (push) begin
         q_data[wr_ptr] <= imem_rsp_data;
         q_pc[wr_ptr]   <= rsp_pc;
      end
   end

   // A response with nothing outstanding means the memory side broke the protocol.
   assert property (@(posedge clk) disable iff (reset) imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: random memory latency/ready/decode stall and redirects,
// checked each cycle against a queue-level model of the fetch stream.
module tb_instr_fetch_queue;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        ins_valid;
   logic        ins_ready = 1'b0;
   logic [31:0] ins_data;
   logic [31:0] ins_pc;
   logic [2:0]  ins_count;
   logic        fetch_fault;

   always #5 clk = ~clk;

   instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data), .ins_pc(ins_pc),
      .ins_count(ins_count), .fetch_fault(fetch_fault)
   );

   typedef struct { logic [31:0] addr; int unsigned rdy; } mem_ent_t;

   mem_ent_t    mem_q[$];      // requests accepted by the memory, in order
   logic [63:0] exp_q[$];      // model queue contents {pc, data}
   logic [32:0] outst_q[$];    // model in-flight requests {dropped, addr}
   logic [31:0] m_fetch_pc;
   bit          m_fault;
   bit          m_started;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   bit          rdy_random = 1'b0;
   int          ins_ready_mode = 1;   // 0 low, 1 high, 2 random
   int unsigned lat_min = 1;
   int unsigned lat_max = 1;

   logic [31:0] popped_pc[$];
   logic [31:0] popped_data[$];
   logic [31:0] fired_addr[$];
   int          npop = 0;
   bit          last_ins_valid;
   bit          last_req_valid;
   logic [2:0]  last_count;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h13579BDF;
   endfunction

   function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
   endfunction

   task automatic clear_logs();
      popped_pc.delete();
      popped_data.delete();
      fired_addr.delete();
   endtask

   task automatic apply_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset = 1'b1;
         imem_req_ready = 1'b0;
         imem_rsp_valid = 1'b0;
         imem_rsp_data = 32'h0;
         redirect_valid = 1'b0;
         redirect_pc = 32'h0;
         ins_ready = 1'b0;
         #1;
         check("rst_req_valid", 32'(imem_req_valid), 32'd0);
         check("rst_ins_valid", 32'(ins_valid), 32'd0);
         check("rst_count", 32'(ins_count), 32'd0);
         cyc++;
      end
      mem_q.delete();
      exp_q.delete();
      outst_q.delete();
      m_fetch_pc = 32'h0;
      m_fault = 1'b0;
      m_started = 1'b0;
   endtask

   // One clock cycle: drive inputs after negedge, compare outputs, then advance memory and model.
   task automatic step(input bit redir, input logic [31:0] rpc);
      bit          rsp, exp_req, exp_ins, fire_m, pop_m, fire_d, pop_d;
      logic [32:0] o;
      int unsigned lat;
      @(negedge clk);
      reset = 1'b0;
      rsp = (mem_q.size() != 0) && (mem_q[0].rdy <= cyc);
      imem_rsp_valid = rsp;
      imem_rsp_data = rsp ? memfn(mem_q[0].addr) : $urandom;
      imem_req_ready = rdy_random ? 1'($urandom_range(1, 0)) : 1'b1;
      case (ins_ready_mode)
         0: ins_ready = 1'b0;
         1: ins_ready = 1'b1;
         default: ins_ready = 1'($urandom_range(1, 0));
      endcase
      redirect_valid = redir;
      redirect_pc = rpc;
      #1;
      exp_req = m_started && ((exp_q.size() + outst_q.size()) < DEPTH) && !redir && !m_fault;
      exp_ins = (exp_q.size() != 0) && !redir;
      check("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) check("req_addr", imem_req_addr, m_fetch_pc);
      check("ins_valid", 32'(ins_valid), 32'(exp_ins));
      check("ins_count", 32'(ins_count), 32'(exp_q.size()));
      if (exp_ins) begin
         check("ins_pc", ins_pc, exp_q[0][63:32]);
         check("ins_data", ins_data, exp_q[0][31:0]);
      end
      check("fetch_fault", 32'(fetch_fault), 32'(m_fault));

      fire_d = imem_req_valid && imem_req_ready;
      pop_d = ins_valid && ins_ready;
      last_ins_valid = ins_valid;
      last_req_valid = imem_req_valid;
      last_count = ins_count;
      if (pop_d) begin
         popped_pc.push_back(ins_pc);
         popped_data.push_back(ins_data);
         npop++;
      end
      if (fire_d) fired_addr.push_back(imem_req_addr);

      if (rsp) mem_q.delete(0);
      if (fire_d) begin
         lat = $urandom_range(lat_max, lat_min);
         mem_q.push_back('{addr: imem_req_addr, rdy: cyc + lat});
      end

      fire_m = exp_req && imem_req_ready;
      pop_m = exp_ins && ins_ready;
      if (pop_m) exp_q.delete(0);
      if (rsp && (outst_q.size() != 0)) begin
         o = outst_q.pop_front();
         if (!o[32] && !redir) exp_q.push_back({o[31:0], memfn(o[31:0])});
      end
      if (redir) begin
         exp_q.delete();
         foreach (outst_q[i]) outst_q[i][32] = 1'b1;
         m_fetch_pc = {rpc[31:2], 2'b00};
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
         m_fault = (rpc[1:0] != 2'b00);
`endif
      end else if (fire_m) begin
         outst_q.push_back({1'b0, m_fetch_pc});
         m_fetch_pc = m_fetch_pc + 32'd4;
      end
      m_started = 1'b1;
      cyc++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int n0;
      int budget;
      logic [31:0] rpc;

      // Streaming: ready memory, latency 1, decode always ready
      rdy_random = 1'b0; ins_ready_mode = 1; lat_min = 1; lat_max = 1;
      apply_reset(2);
      clear_logs();
      n0 = 0;
      for (int i = 0; i < 30; i++) begin
         if (i == 10) n0 = npop;
         step(1'b0, 32'h0);
      end
      check("p1_throughput", 32'(npop - n0), 32'd20);
      check("p1_addr0", qget(fired_addr, 0), 32'h0);
      check("p1_addr3", qget(fired_addr, 3), 32'hC);
      check("p1_pc0", qget(popped_pc, 0), 32'h0);
      check("p1_pc2", qget(popped_pc, 2), 32'h8);

      // Decode stalled: queue fills to DEPTH then fetch stops
      ins_ready_mode = 0;
      apply_reset(1);
      clear_logs();
      for (int i = 0; i < 20; i++) step(1'b0, 32'h0);
      check("p2_nfired", 32'(fired_addr.size()), 32'd4);
      check("p2_count", 32'(last_count), 32'd4);
      check("p2_req_held", 32'(last_req_valid), 32'd0);
      ins_ready_mode = 1;
      for (int i = 0; i < 15; i++) step(1'b0, 32'h0);
      check("p2_pc0", qget(popped_pc, 0), 32'h0);
      check("p2_pc3", qget(popped_pc, 3), 32'hC);
      check("p2_pc4", qget(popped_pc, 4), 32'h10);

      // Latency 3 with three in flight, redirect to 0x100
      lat_min = 3; lat_max = 3;
      apply_reset(1);
      budget = 0;
      while ((outst_q.size() != 3) && (budget < 30)) begin
         step(1'b0, 32'h0);
         budget++;
      end
      check("p3_setup", 32'(outst_q.size()), 32'd3);
      clear_logs();
      step(1'b1, 32'h100);
      for (int i = 0; i < 20; i++) step(1'b0, 32'h0);
      check("p3_fire0", qget(fired_addr, 0), 32'h100);
      check("p3_pc0", qget(popped_pc, 0), 32'h100);
      check("p3_data0", qget(popped_data, 0), memfn(32'h100));
      check("p3_pc1", qget(popped_pc, 1), 32'h104);

      // Redirect coinciding with a response and a pop attempt while two entries are held
      lat_min = 1; lat_max = 1; ins_ready_mode = 0;
      apply_reset(1);
      budget = 0;
      while (!((exp_q.size() == 2) && (mem_q.size() != 0) && (mem_q[0].rdy <= cyc)) && (budget < 30)) begin
         step(1'b0, 32'h0);
         budget++;
      end
      check("p4_setup", 32'(exp_q.size()), 32'd2);
      ins_ready_mode = 1;
      n0 = npop;
      step(1'b1, 32'h40);
      check("p4_ins_valid", 32'(last_ins_valid), 32'd0);
      check("p4_no_pop", 32'(npop - n0), 32'd0);
      step(1'b0, 32'h0);
      check("p4_count_next", 32'(last_count), 32'd0);
      for (int i = 0; i < 8; i++) step(1'b0, 32'h0);

      // Random ready, latency, decode stall and redirects, including a PC wrap
      rdy_random = 1'b1; ins_ready_mode = 2; lat_min = 1; lat_max = 4;
      apply_reset(1);
      step(1'b0, 32'h0);
      step(1'b1, 32'hFFFF_FFF8);
      for (int i = 0; i < 200; i++) begin
         rpc = $urandom & 32'h0000_FFFC;
         step($urandom_range(24, 0) == 0, rpc);
      end

      // Misaligned redirect
      rdy_random = 1'b0; ins_ready_mode = 1; lat_min = 1; lat_max = 1;
      apply_reset(1);
      for (int i = 0; i < 8; i++) step(1'b0, 32'h0);
      clear_logs();
      step(1'b1, 32'h102);
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
      check("p6_fault_set", 32'(fetch_fault), 32'd1);
      check("p6_no_fetch", 32'(fired_addr.size()), 32'd0);
      clear_logs();
      step(1'b1, 32'h200);
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
      check("p6_fault_clr", 32'(fetch_fault), 32'd0);
      check("p6_resume", qget(fired_addr, 0), 32'h200);
`else
      check("p6_fault_tied", 32'(fetch_fault), 32'd0);
      check("p6_aligned", qget(fired_addr, 0), 32'h100);
      check("p6_pc0", qget(popped_pc, 0), 32'h100);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
